// File: rtl/boot_dly_seq_ctrl_if.sv
// Bundle of boot-step and request-channel signals between the sequencer (slave)
// and the bring-up / transaction-engine side (master).
interface boot_dly_seq_ctrl_if #(
   parameter int BOOT_STEPS = 2,
   parameter int NCH        = 2,
   parameter int TMO_W      = 16
);
   localparam int IDX_W = (BOOT_STEPS > 1) ? $clog2(BOOT_STEPS) : 1;

   // Handshake: every *_req / *_ack / step_done input and every *_start / *_done /
   // *_timeout output is a single-cycle pulse sampled on the rising clock edge;
   // ch_grant is a level held for the whole service window of one channel.
   logic                 step_done;
   logic                 step_start;
   logic [IDX_W-1:0]     step_idx;
   logic                 boot_pass;
   logic                 boot_fail;
   logic [NCH-1:0]       ch_req;
   logic [NCH-1:0]       ch_ack;
   logic [NCH*TMO_W-1:0] ch_tmo_ms;
   logic [NCH-1:0]       ch_grant;
   logic [NCH-1:0]       ch_done;
   logic [NCH-1:0]       ch_timeout;
   logic                 busy;
   logic [2:0]           dbg_state;

   modport master (
      output step_done, ch_req, ch_ack, ch_tmo_ms,
      input  step_start, step_idx, boot_pass, boot_fail,
             ch_grant, ch_done, ch_timeout, busy, dbg_state
   );

   modport slave (
      input  step_done, ch_req, ch_ack, ch_tmo_ms,
      output step_start, step_idx, boot_pass, boot_fail,
             ch_grant, ch_done, ch_timeout, busy, dbg_state
   );
endinterface

// File: rtl/boot_dly_seq_ctrl.sv
// Boot sequencer (power settle, watchdogged read steps) followed by a fixed-priority
// arbiter that serves request channels with a per-channel millisecond timeout.
module boot_dly_seq_ctrl #(
   parameter int CLK_PER_MS   = 60000,
   parameter int PWR_DELAY_MS = 5000,
   parameter int BOOT_STEPS   = 2,
   parameter int STEP_GAP_MS  = 15,
   parameter int STEP_TMO_MS  = 50,
   parameter int NCH          = 2,
   parameter int TMO_W        = 16
) (
   input logic                i_clk,
   input logic                i_rst_n,
   boot_dly_seq_ctrl_if.slave bus
);

   localparam int IDX_W  = (BOOT_STEPS > 1) ? $clog2(BOOT_STEPS) : 1;
   localparam int PRE_W  = $clog2(CLK_PER_MS);
   localparam int MAX_A  = (PWR_DELAY_MS > STEP_GAP_MS) ? PWR_DELAY_MS : STEP_GAP_MS;
   localparam int MAX_B  = (MAX_A > STEP_TMO_MS) ? MAX_A : STEP_TMO_MS;
   localparam int MAX_T  = (1 << TMO_W) - 1;
   localparam int MAX_MS = (MAX_B > MAX_T) ? MAX_B : MAX_T;
   localparam int MS_W   = $clog2(MAX_MS + 1);

   typedef enum logic [2:0] {
      S_BOOT     = 3'd0,
      S_PWR_DLY  = 3'd1,
      S_STEP_RUN = 3'd2,
      S_STEP_GAP = 3'd3,
      S_IDLE     = 3'd4,
      S_CH_ACT   = 3'd5,
      S_FAIL     = 3'd6
   } state_t;

   state_t               state, state_nxt;
   logic [PRE_W-1:0]     pre_q;
   logic [MS_W-1:0]      ms_q;
   logic                 tick;
   logic [IDX_W-1:0]     idx_q;
   logic                 step_start_q;
   logic                 pass_q, fail_q;
   logic [NCH-1:0]       pend_q, grant_q, done_q, tout_q;
   logic [TMO_W-1:0]     tmo_q;

   logic [NCH-1:0]       sel_oh;
   logic [TMO_W-1:0]     tmo_sel;
   logic                 grant_load, done_fire, tmo_fire;
   logic                 pass_set, fail_set, idx_inc;

   assign tick = (pre_q == PRE_W'(CLK_PER_MS - 1));

   // Lowest pending index wins; its timeout field is picked alongside.
   always_comb begin
      sel_oh  = '0;
      tmo_sel = '0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (pend_q[c]) begin
            sel_oh    = '0;
            sel_oh[c] = 1'b1;
            tmo_sel   = bus.ch_tmo_ms[c*TMO_W +: TMO_W];
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      grant_load = 1'b0;
      done_fire  = 1'b0;
      tmo_fire   = 1'b0;
      pass_set   = 1'b0;
      fail_set   = 1'b0;
      idx_inc    = 1'b0;
      case (state)
         S_BOOT: state_nxt = S_PWR_DLY;
         S_PWR_DLY: begin
            if (tick && ms_q == MS_W'(PWR_DELAY_MS - 1))
               state_nxt = S_STEP_RUN;
         end
         S_STEP_RUN: begin
            // A completion seen on the watchdog's final tick still counts as success.
            if (bus.step_done) begin
               if (idx_q == IDX_W'(BOOT_STEPS - 1)) begin
                  state_nxt = S_IDLE;
                  pass_set  = 1'b1;
               end else begin
                  state_nxt = S_STEP_GAP;
               end
            end else if (tick && ms_q == MS_W'(STEP_TMO_MS - 1)) begin
               state_nxt = S_FAIL;
               fail_set  = 1'b1;
            end
         end
         S_STEP_GAP: begin
            if (tick && ms_q == MS_W'(STEP_GAP_MS - 1)) begin
               state_nxt = S_STEP_RUN;
               idx_inc   = 1'b1;
            end
         end
         S_IDLE: begin
            if (|pend_q) begin
               state_nxt  = S_CH_ACT;
               grant_load = 1'b1;
            end
         end
         S_CH_ACT: begin
            if (|(bus.ch_ack & grant_q)) begin
               state_nxt = S_IDLE;
               done_fire = 1'b1;
            end else if (tick && ms_q == MS_W'(tmo_q - TMO_W'(1))) begin
               state_nxt = S_IDLE;
               tmo_fire  = 1'b1;
            end
         end
         S_FAIL: state_nxt = S_FAIL;
         default: state_nxt = S_BOOT;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= S_BOOT;
      else          state <= state_nxt;
   end

   // Timebase restarts on every state change and idles in untimed states.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else if (state_nxt != state || state == S_BOOT ||
                   state == S_IDLE || state == S_FAIL) begin
         pre_q <= '0;
         ms_q  <= '0;
      end else if (tick) begin
         pre_q <= '0;
         ms_q  <= ms_q + MS_W'(1);
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         idx_q        <= '0;
         step_start_q <= 1'b0;
         pass_q       <= 1'b0;
         fail_q       <= 1'b0;
         pend_q       <= '0;
         grant_q      <= '0;
         done_q       <= '0;
         tout_q       <= '0;
         tmo_q        <= TMO_W'(1);
      end else begin
         step_start_q <= (state_nxt == S_STEP_RUN) && (state != S_STEP_RUN);
         if (idx_inc)  idx_q  <= idx_q + IDX_W'(1);
         if (pass_set) pass_q <= 1'b1;
         if (fail_set) fail_q <= 1'b1;
         // New requests override the grant-time clear of the same bit.
         pend_q <= (pend_q & ~(grant_load ? sel_oh : '0)) | bus.ch_req;
         if (grant_load) begin
            grant_q <= sel_oh;
            tmo_q   <= (tmo_sel == '0) ? TMO_W'(1) : tmo_sel;
         end else if (done_fire || tmo_fire) begin
            grant_q <= '0;
         end
         done_q <= done_fire ? grant_q : '0;
         tout_q <= tmo_fire  ? grant_q : '0;
      end
   end

   assign bus.step_start = step_start_q;
   assign bus.step_idx   = idx_q;
   assign bus.boot_pass  = pass_q;
   assign bus.boot_fail  = fail_q;
   assign bus.ch_grant   = grant_q;
   assign bus.ch_done    = done_q;
   assign bus.ch_timeout = tout_q;
   assign bus.busy       = (state != S_IDLE);
   assign bus.dbg_state  = state;

endmodule

// File: doc/boot_dly_seq_ctrl.md
# boot_dly_seq_ctrl

Parametrised boot sequencer and multi-channel delay/timeout controller. It sits between the camera power/I2C bring-up logic and the runtime transaction engines (I2C, loop-TX, …). After reset it runs a power-settle delay and a configurable number of boot read steps, each with a gap and a watchdog. It then arbitrates N request channels, each served with a runtime-programmable millisecond timeout.

## Interface
- CLK_PER_MS, 60000, i_clk cycles per millisecond tick (≥2)
- PWR_DELAY_MS, 5000, power-settle delay after reset (≥1)
- BOOT_STEPS, 2, number of boot read steps (≥1)
- STEP_GAP_MS, 15, delay between consecutive boot steps (≥1)
- STEP_TMO_MS, 50, watchdog per boot step (≥1)
- NCH, 2, runtime request channels (≥1); index 0 highest priority
- TMO_W, 16, width of each channel timeout field

- i_clk  in  1  clock
- i_rst_n  in  1  reset; synchronous, active-low
- i_step_done  in  1  pulse: current boot step complete (e.g. I2C busy falling edge)
- o_step_start  out  1  one-cycle pulse launching boot step o_step_idx
- o_step_idx  out  clog2(BOOT_STEPS) max 1  current boot step index
- o_boot_pass  out  1  sticky: boot finished successfully
- o_boot_fail  out  1  sticky: a boot step watchdog expired
- i_ch_req  in  NCH  per-channel request pulses
- i_ch_ack  in  NCH  per-channel completion pulses
- i_ch_tmo_ms  in  NCH*TMO_W  per-channel timeout in ms; field c at [c*TMO_W +: TMO_W]
- o_ch_grant  out  NCH  one-hot, held while the channel is active
- o_ch_done  out  NCH  one-cycle pulse: ack received
- o_ch_timeout  out  NCH  one-cycle pulse: channel timed out
- o_busy  out  1  state ≠ IDLE

## Operation
- States: BOOT, PWR_DLY, STEP_RUN, STEP_GAP, IDLE, CH_ACT, FAIL.
- BOOT → PWR_DLY unconditionally.
- PWR_DLY → STEP_RUN after PWR_DELAY_MS. Entry into STEP_RUN issues o_step_start.
- STEP_RUN:
  - i_step_done with o_step_idx = BOOT_STEPS-1 → IDLE, and o_boot_pass ← 1.
  - i_step_done otherwise → STEP_GAP.
  - STEP_TMO_MS elapsed → FAIL, and o_boot_fail ← 1.
  - i_step_done wins over a same-cycle watchdog expiry.
- STEP_GAP → STEP_RUN after STEP_GAP_MS, with o_step_idx incremented.
- FAIL is terminal until reset. Channel requests are still captured in FAIL but never granted.
- Pending register: bit c is set by i_ch_req[c] in every state, including the boot states. It is cleared when channel c is granted. If a request arrives in the same cycle as the clear, set wins.
- IDLE:
  - If any pending bit is set, grant the lowest index c and go to CH_ACT.
  - Latch i_ch_tmo_ms[c] into the timeout register. A value of 0 is treated as 1.
- CH_ACT:
  - i_ch_ack[c] → o_ch_done[c] pulse, IDLE.
  - Latched timeout elapsed → o_ch_timeout[c] pulse, IDLE.
  - Ack wins over a same-cycle timeout.
  - Acks on non-granted channels are ignored.
- A request to the active channel during CH_ACT re-sets its pending bit, so the channel is served again afterwards.
- Timebase:
  - The prescaler counts 0…CLK_PER_MS-1 and produces a tick at CLK_PER_MS-1.
  - The ms counter increments on each tick.
  - Both counters clear on every state entry and are held at 0 in BOOT, IDLE and FAIL.
  - Widths are sized to the largest of PWR_DELAY_MS, STEP_GAP_MS, STEP_TMO_MS and 2^TMO_W-1.

## Timing
- Reset values: o_step_start=0, o_step_idx=0, o_boot_pass=0, o_boot_fail=0, o_ch_grant=0, o_ch_done=0, o_ch_timeout=0, o_busy=1, pending=0, state=BOOT.
- Each timed state (PWR_DLY, STEP_GAP) lasts exactly D×CLK_PER_MS cycles, where D is its delay in ms.
- Watchdog and channel timeout: the exit edge is the edge of the D-th tick.
- o_step_start is asserted during the first cycle of each STEP_RUN visit.
- Request → grant: i_ch_req sampled at edge k sets pending. If the state is IDLE, o_ch_grant is asserted from edge k+1.
- Ack at edge k → o_ch_done pulse and grant drop at edge k+1. State is IDLE for at least 1 cycle before the next grant.
- o_boot_pass rises on the same edge the state enters IDLE.

## Test plan
Configuration for all scenarios: CLK_PER_MS=4, PWR_DELAY_MS=3, BOOT_STEPS=2, STEP_GAP_MS=2, STEP_TMO_MS=5, NCH=3, TMO_W=8.

- Reset, then i_step_done 10 cycles after each o_step_start → PWR_DLY lasts 12 cycles; o_step_start at idx 0, then after an 8-cycle gap at idx 1; o_boot_pass=1, o_busy=0.
- Withhold i_step_done in step 0 → FAIL after 20 cycles; o_boot_fail=1; a later i_ch_req[0] gives no grant.
- After boot, pulse i_ch_req=3'b110 with tmo=5, 7 → grant 3'b010; ack 6 cycles later gives o_ch_done[1]; then grant 3'b100.
- Channel 0 with tmo=2 and no ack → o_ch_timeout[0] exactly 8 cycles after grant; grant drops.
- Ack arrives on the same cycle as the timeout tick → only o_ch_done fires.
- Requests on channel 2 during PWR_DLY, tmo=0 → granted on IDLE entry; times out after 4 cycles.
